bpsk_modulator_top: RTL and testbench
=====================================

Name: bpsk_modulator_top

Overview:
Transmit-side counterpart of bpsk_demodulator_top. Accepts bytes over a valid/ready handshake and serialises them MSB first, one bit per SAMPLES_PER_SYMBOL clocks. Each symbol is emitted as a signed carrier sample stream: +cos for bit 1, -cos for bit 0. Each transmission is prefixed by an alternating preamble so the demodulator can lock. One sample per clock. Carrier comes from an internal cosine_lut instance (READ_PORTS=1) driven by a free-running phase accumulator.

Parameters:
SAMPLE_WIDTH, `FIXDT_64_A_WIDTH, signed sample width (matches cosine_lut output and demodulator data_in)
SAMPLES_PER_SYMBOL, `SAMPLES_PER_SYMBOL, clocks per transmitted bit (>=2)
LUT_DEPTH, `CARRIER_SAMPLES_PER_PERIOD, cosine_lut entries; phase width = $clog2(LUT_DEPTH)
PHASE_STEP, `CARRIER_SAMPLES_PER_PERIOD/(`SAMPLING_FREQ/`CARRIER_FREQ), phase increment per clock
PREAMBLE_SYMBOLS, 16, alternating symbols sent before the first byte of a burst (0 = none)

Ports:
clk  in  1  system clock, one sample per cycle
rst  in  1  asynchronous reset, active-low
byte_in  in  8  data byte to transmit
byte_valid  in  1  byte_in valid
byte_ready  out  1  holding register empty; transfer when byte_valid && byte_ready on posedge clk
sample_out  out  SAMPLE_WIDTH  signed modulated sample, registered
sample_valid  out  1  sample_out carries a transmitted symbol
sym_strobe  out  1  one-cycle pulse aligned with first sample of each symbol
busy  out  1  FSM not IDLE or holding register full

Behaviour:
- Reset (rst=0, async): phase=0, symbol counter=0, state=IDLE, hold register empty, shift register=0. Outputs: sample_out=0, sample_valid=0, sym_strobe=0, busy=0, byte_ready=1. An in-flight byte is discarded. Leaving reset is synchronous to the next posedge.
- Phase accumulator: increments by PHASE_STEP every cycle regardless of state and wraps modulo LUT_DEPTH. This keeps the carrier phase continuous across idle gaps.
- Holding register (1 entry):
  - byte_ready = !hold_full.
  - Handshake loads it.
  - Cleared when the FSM loads it into the shift register.
  - Accept and unload in the same cycle cannot happen because ready is low while full.
- FSM states: IDLE, PREAMBLE, DATA.
  - IDLE: on the edge where hold_full=1, load the shift register, clear hold, set symbol counter=0, bit index=0. Go to PREAMBLE (or DATA if PREAMBLE_SYMBOLS=0).
  - PREAMBLE: current bit = 1 on even preamble index, 0 on odd (first symbol is 1). After PREAMBLE_SYMBOLS symbols, go to DATA.
  - DATA: current bit = shift_reg[7], shift left at each symbol end. After the 8th symbol:
    - if hold_full, reload and stay in DATA (back-to-back, no preamble, no gap);
    - else go to IDLE.
- Symbol counter: runs 0..SAMPLES_PER_SYMBOL-1 while not IDLE. Wrap marks the symbol end.
- Sample datapath:
  - LUT output c = cos(phase).
  - Combinational s = bit ? c : -c, with two's-complement negation; if c is the most negative value, -c saturates to the maximum positive value.
  - sample_out <= s and sample_valid <= (state != IDLE), a 1-cycle register stage.
  - In IDLE, sample_out <= 0.
  - sym_strobe is registered alongside sample_out, high when the symbol counter was 0.
- Latency: byte accepted at edge N, FSM leaves IDLE at edge N+1, first valid sample (with sym_strobe) appears after edge N+2.
- Burst length: (PREAMBLE_SYMBOLS + 8*k) * SAMPLES_PER_SYMBOL valid samples for k back-to-back bytes, with sample_valid continuous.
- A byte_valid held while byte_ready=0 has no effect. byte_in must stay stable until accepted.

Test Plan:
- SPS=8, PREAMBLE=4. Reset, then send 0xA5.
  - byte_ready falls one cycle after the handshake.
  - Exactly 96 consecutive sample_valid cycles and 12 sym_strobes.
  - Sample signs per symbol follow 1,0,1,0 then 1,0,1,0,0,1,0,1.
  - busy falls after the last sample.
- Send 0xFF then 0x00 back-to-back (second offered while the first is in DATA).
  - No gap in sample_valid; 160 samples total.
  - First 8 data symbols equal +cos, next 8 equal -cos.
  - Only one preamble is sent.
- Phase check, PHASE_STEP=1: every valid sample equals ±LUT[(cycle-1) mod LUT_DEPTH] against a reference model, including after a 37-cycle idle gap between bytes.
- Force a LUT entry equal to the most negative value with bit=0 -> sample_out = max positive, no wrap.
- Assert rst low mid-DATA (3rd bit of 0x3C).
  - All outputs clear asynchronously; byte_ready=1.
  - Next byte 0x81 transmits with a full preamble and no residue of 0x3C.
- Loopback into bpsk_demodulator_top with 200 random bytes and random idle gaps -> recovered bitstream matches the transmitted bits after demodulator latency.

Source files
------------

// File: rtl/bpsk_modulator_top.sv
// BPSK transmitter: bytes in over valid/ready, serialised MSB first as +/-cos
// carrier samples, each burst prefixed by an alternating 1/0 preamble.

module cosine_lut #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int READ_PORTS = 1,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [READ_PORTS*AW-1:0]         phase,
  output logic [READ_PORTS*DATA_WIDTH-1:0] cos_out
);

  logic [DATA_WIDTH-1:0] rom [DEPTH];

  // Full-scale 2^(W-1) cosine; only the +1.0 peak needs clipping, so the
  // -1.0 entry lands exactly on the most negative code.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real    ANGLE   = 6.283185307179586 * real'(k) / real'(DEPTH);
    localparam longint MAX_POS = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;
    localparam longint RAW     = longint'(real'(MAX_POS + 1) * $cos(ANGLE));
    localparam longint CLIPPED = (RAW > MAX_POS) ? MAX_POS : RAW;
    assign rom[k] = DATA_WIDTH'(CLIPPED);
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    assign cos_out[p*DATA_WIDTH +: DATA_WIDTH] = rom[phase[p*AW +: AW]];
  end

endmodule

module bpsk_modulator_top #(
  parameter int SAMPLE_WIDTH       = 16,
  parameter int SAMPLES_PER_SYMBOL = 8,
  parameter int LUT_DEPTH          = 32,
  parameter int PHASE_STEP         = 4,
  parameter int PREAMBLE_SYMBOLS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  output logic                           byte_ready,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_valid,
  output logic                           sym_strobe,
  output logic                           busy
);

  localparam int PW       = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
  localparam int CW       = $clog2(SAMPLES_PER_SYMBOL);
  localparam int IDX_SPAN = (PREAMBLE_SYMBOLS > 8) ? PREAMBLE_SYMBOLS : 8;
  localparam int IW       = $clog2(IDX_SPAN);
  localparam logic signed [SAMPLE_WIDTH-1:0] S_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [SAMPLE_WIDTH-1:0] S_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t                          state_q, state_d;
  logic [PW-1:0]                   phase_q, phase_d;
  logic [PW:0]                     phase_sum;
  logic [CW-1:0]                   sym_cnt_q, sym_cnt_d;
  logic [IW-1:0]                   sym_idx_q, sym_idx_d;
  logic [7:0]                      shift_q, shift_d;
  logic [7:0]                      hold_q, hold_d;
  logic                            hold_full_q, hold_full_d;
  logic signed [SAMPLE_WIDTH-1:0]  sample_q, sample_d;
  logic                            sample_valid_q, sample_valid_d;
  logic                            sym_strobe_q, sym_strobe_d;

  logic [SAMPLE_WIDTH-1:0]         carrier_raw;
  logic signed [SAMPLE_WIDTH-1:0]  carrier, carrier_neg, mod_sample;
  logic                            sym_end, cur_bit, accept, load_hold;

  cosine_lut #(
    .DATA_WIDTH (SAMPLE_WIDTH),
    .DEPTH      (LUT_DEPTH),
    .READ_PORTS (1)
  ) u_lut (
    .phase   (phase_q),
    .cos_out (carrier_raw)
  );

  assign carrier = $signed(carrier_raw);

  // Free-running so the carrier stays phase-continuous across idle gaps.
  always_comb begin
    phase_sum = {1'b0, phase_q} + (PW+1)'(PHASE_STEP);
    if (phase_sum >= (PW+1)'(LUT_DEPTH)) phase_sum = phase_sum - (PW+1)'(LUT_DEPTH);
    phase_d = phase_sum[PW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    sym_idx_d   = sym_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load_hold   = 1'b0;
    cur_bit     = 1'b0;
    accept      = byte_valid && !hold_full_q;
    sym_end     = (state_q != IDLE) && (sym_cnt_q == CW'(SAMPLES_PER_SYMBOL - 1));

    unique case (state_q)
      IDLE: begin
        sym_cnt_d = '0;
        sym_idx_d = '0;
        if (hold_full_q) begin
          load_hold = 1'b1;
          state_d   = (PREAMBLE_SYMBOLS > 0) ? PREAMBLE : DATA;
        end
      end
      PREAMBLE: begin
        cur_bit = ~sym_idx_q[0];
        if (sym_end) begin
          if (int'(sym_idx_q) == PREAMBLE_SYMBOLS - 1) begin
            sym_idx_d = '0;
            state_d   = DATA;
          end else begin
            sym_idx_d = sym_idx_q + 1'b1;
          end
        end
      end
      DATA: begin
        cur_bit = shift_q[7];
        if (sym_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (sym_idx_q == IW'(7)) begin
            sym_idx_d = '0;
            // A byte already waiting continues the burst with no gap or preamble.
            if (hold_full_q) load_hold = 1'b1;
            else             state_d   = IDLE;
          end else begin
            sym_idx_d = sym_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) sym_cnt_d = sym_end ? '0 : sym_cnt_q + 1'b1;

    if (load_hold) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = byte_in;
      hold_full_d = 1'b1;
    end
  end

  // -S_MIN is not representable, so it saturates to S_MAX.
  always_comb begin
    carrier_neg    = (carrier == S_MIN) ? S_MAX : -carrier;
    mod_sample     = cur_bit ? carrier : carrier_neg;
    sample_d       = (state_q != IDLE) ? mod_sample : '0;
    sample_valid_d = (state_q != IDLE);
    sym_strobe_d   = (state_q != IDLE) && (sym_cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      sym_cnt_q      <= '0;
      sym_idx_q      <= '0;
      shift_q        <= '0;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sym_strobe_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      sym_cnt_q      <= sym_cnt_d;
      sym_idx_q      <= sym_idx_d;
      shift_q        <= shift_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sym_strobe_q   <= sym_strobe_d;
    end
  end

  assign byte_ready   = !hold_full_q;
  assign busy         = (state_q != IDLE) || hold_full_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign sym_strobe   = sym_strobe_q;

endmodule

// File: tb/tb_bpsk_modulator_top.sv
// Bench for bpsk_modulator_top: symbol-queue reference model checked every
// cycle, plus literal checks on burst length, saturation and reset.

module tb_bpsk_modulator_top;

  localparam int SW    = 12;
  localparam int SPS   = 8;
  localparam int DEPTH = 16;
  localparam int STEP  = 1;
  localparam int PRE   = 4;
  localparam int SMAX  = (1 << (SW - 1)) - 1;
  localparam int SMIN  = -(1 << (SW - 1));

  logic                 clk;
  logic                 rst;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_ready;
  logic signed [SW-1:0] sample_out;
  logic                 sample_valid;
  logic                 sym_strobe;
  logic                 busy;

  bpsk_modulator_top #(
    .SAMPLE_WIDTH       (SW),
    .SAMPLES_PER_SYMBOL (SPS),
    .LUT_DEPTH          (DEPTH),
    .PHASE_STEP         (STEP),
    .PREAMBLE_SYMBOLS   (PRE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sym_strobe   (sym_strobe),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: quantised cosine and a queue of pending symbol bits.
  function automatic int lut_val(input int idx);
    real a;
    int  v;
    a = (2.0 ** (SW - 1)) * $cos(6.283185307179586 * real'(idx) / real'(DEPTH));
    v = int'(a);
    if (v > SMAX) v = SMAX;
    return v;
  endfunction

  function automatic int mod_val(input bit b, input int idx);
    int c;
    c = lut_val(idx);
    if (b) return c;
    return (c == SMIN) ? SMAX : -c;
  endfunction

  bit   m_sym[$];
  int   m_cnt, m_phase;
  bit   m_hold_full;
  logic [7:0] m_hold;
  bit   e_valid, e_strobe, e_bit;
  int   e_sample, e_phase;

  task automatic model_reset();
    m_sym.delete();
    m_cnt = 0; m_phase = 0; m_hold_full = 0; m_hold = '0;
    e_valid = 0; e_strobe = 0; e_bit = 0; e_sample = 0; e_phase = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) m_sym.push_back(b[i]);
  endtask

  task automatic model_step();
    bit pre_full;
    pre_full = m_hold_full;
    if (m_sym.size() > 0) begin
      e_valid  = 1;
      e_bit    = m_sym[0];
      e_strobe = (m_cnt == 0);
      e_sample = mod_val(e_bit, m_phase);
      e_phase  = m_phase;
      m_cnt++;
      if (m_cnt == SPS) begin
        m_cnt = 0;
        void'(m_sym.pop_front());
        if (m_sym.size() == 0 && pre_full) begin
          push_byte(m_hold);
          m_hold_full = 0;
        end
      end
    end else begin
      e_valid = 0; e_strobe = 0; e_sample = 0;
      if (pre_full) begin
        for (int i = 0; i < PRE; i++) m_sym.push_back(i % 2 == 0);
        push_byte(m_hold);
        m_hold_full = 0;
      end
    end
    if (byte_valid && !pre_full) begin
      m_hold      = byte_in;
      m_hold_full = 1;
    end
    m_phase = (m_phase + STEP) % DEPTH;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  int run_len = 0, run_strobes = 0, last_run = 0, last_strobes = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check("sample_valid", int'(sample_valid), int'(e_valid));
        check("sample_out",   int'(sample_out),   e_sample);
        check("sym_strobe",   int'(sym_strobe),   int'(e_strobe));
        check("busy",         int'(busy),         int'(m_sym.size() > 0 || m_hold_full));
        check("byte_ready",   int'(byte_ready),   int'(!m_hold_full));
        if (e_valid && e_phase == DEPTH / 2 && !e_bit) check("sat_neg_min", int'(sample_out), 2047);
        if (e_valid && e_phase == 0) check("peak_lit", int'(sample_out), e_bit ? 2047 : -2047);
        if (e_valid && e_phase == 2) check("oct_lit", int'(sample_out), e_bit ? 1448 : -1448);
        if (e_valid && e_phase == 4) check("zero_lit", int'(sample_out), 0);
      end
      if (sample_valid) begin
        run_len++;
        if (sym_strobe) run_strobes++;
      end else if (run_len > 0) begin
        last_run = run_len; last_strobes = run_strobes;
        run_len = 0; run_strobes = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("send_timeout", 0, 1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; byte_in = '0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    checking = 1;
    @(negedge clk);
    #2 rst = 1'b1;

    // Single byte with preamble
    @(negedge clk);
    send_byte(8'hA5);
    check("ready_after_accept", int'(byte_ready), 0);
    wait_idle();
    check("a5_run_len", last_run, (PRE + 8) * SPS);
    check("a5_strobes", last_strobes, PRE + 8);

    // Back-to-back bytes share one preamble
    send_byte(8'hFF);
    repeat (50) @(negedge clk);
    send_byte(8'h00);
    wait_idle();
    check("b2b_run_len", last_run, (PRE + 16) * SPS);
    check("b2b_strobes", last_strobes, PRE + 16);

    // Idle gap of 37 cycles keeps carrier phase continuous
    send_byte(8'h5A);
    wait_idle();
    repeat (37) @(negedge clk);
    send_byte(8'hC3);
    wait_idle();
    check("gap_run_len", last_run, (PRE + 8) * SPS);

    // Async reset during the third data bit of 0x3C
    send_byte(8'h3C);
    repeat (PRE * SPS + 2 * SPS + 3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_sample_out",   int'(sample_out),   0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_sym_strobe",   int'(sym_strobe),   0);
    check("rst_busy",         int'(busy),         0);
    check("rst_byte_ready",   int'(byte_ready),   1);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    send_byte(8'h81);
    wait_idle();
    check("post_rst_run_len", last_run, (PRE + 8) * SPS);
    check("post_rst_strobes", last_strobes, PRE + 8);

    // Random bytes with random idle gaps
    for (int n = 0; n < 200; n++) begin
      int gap;
      gap = int'($urandom_range(0, 40));
      if (gap > 30) wait_idle();
      repeat (gap % 12) @(negedge clk);
      send_byte(8'($urandom));
    end
    wait_idle();

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
